// File: rtl/fir_coeff_bank_ctrl_if.sv
// fir_coeff_bank_ctrl_if: config bus, sample handshake and FIR-side outputs of the coefficient bank controller
interface fir_coeff_bank_ctrl_if #(
    parameter int CW = 10,
    parameter int FN = 8,
    parameter int AW = $clog2(FN)
);
    logic             clear;
    logic             cfg_wr_en;
    logic [AW-1:0]    cfg_wr_addr;
    logic [CW-1:0]    cfg_wr_data;
    logic             cfg_commit;
    logic             cfg_busy;
    logic             cfg_err;
    logic             data_in_vld;
    logic             in_rdy;
    logic             fir_in_vld;
    logic             fir_clear;
    logic [FN*CW-1:0] coeff_out;
    logic             bank_sel;
    logic             swap_done;
    logic [7:0]       swap_cnt;

    modport slave (
        input  clear, cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit, data_in_vld,
        output cfg_busy, cfg_err, in_rdy, fir_in_vld, fir_clear, coeff_out,
               bank_sel, swap_done, swap_cnt
    );

    modport master (
        output clear, cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit, data_in_vld,
        input  cfg_busy, cfg_err, in_rdy, fir_in_vld, fir_clear, coeff_out,
               bank_sel, swap_done, swap_cnt
    );
endinterface

// File: rtl/fir_coeff_bank_ctrl.sv
// fir_coeff_bank_ctrl: double-buffered FIR coefficient banks with a stalling swap/flush sequence
module fir_coeff_bank_ctrl #(
    parameter int CW       = 10,
    parameter int FW       = 15,
    parameter int FLUSH_EN = 1
) (
    input logic                  clk,
    input logic                  rstn,
    fir_coeff_bank_ctrl_if.slave io
);
    localparam int FN = (FW + 1) / 2;
    localparam int AW = $clog2(FN);

    typedef enum logic [1:0] {IDLE, HOLD, SWAP, FLUSH} state_t;

    state_t           state;
    logic [CW-1:0]    bank [2][FN];
    logic [FN-1:0]    mask;
    logic [FN-1:0]    mask_upd;
    logic             bank_sel;
    logic             fir_clear;
    logic             cfg_err;
    logic             swap_done;
    logic [7:0]       swap_cnt;
    logic [FN*CW-1:0] coeff_out;
    logic             addr_ok;
    logic             wr_ok;
    logic             busy_err;

    assign addr_ok  = {1'b0, io.cfg_wr_addr} < (AW+1)'(FN);
    assign wr_ok    = (state == IDLE) && io.cfg_wr_en && addr_ok;
    assign busy_err = io.cfg_wr_en || io.cfg_commit;
    // a write in the same cycle as a commit must already count toward the full-mask test
    assign mask_upd = wr_ok ? (mask | (FN'(1) << io.cfg_wr_addr)) : mask;

    assign io.cfg_busy   = state != IDLE;
    assign io.in_rdy     = state == IDLE;
    assign io.fir_in_vld = io.data_in_vld && (state == IDLE);
    assign io.fir_clear  = fir_clear;
    assign io.cfg_err    = cfg_err;
    assign io.coeff_out  = coeff_out;
    assign io.bank_sel   = bank_sel;
    assign io.swap_done  = swap_done;
    assign io.swap_cnt   = swap_cnt;

    // swap sequencer, shadow-bank writes and all registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            mask      <= '0;
            bank_sel  <= 1'b0;
            fir_clear <= 1'b0;
            cfg_err   <= 1'b0;
            swap_done <= 1'b0;
            swap_cnt  <= '0;
            coeff_out <= '0;
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < FN; k++)
                    bank[b][k] <= '0;
        end else if (io.clear) begin
            state     <= IDLE;
            mask      <= '0;
            fir_clear <= 1'b1;
            cfg_err   <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            fir_clear <= 1'b0;
            cfg_err   <= 1'b0;
            swap_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_ok)
                        bank[~bank_sel][io.cfg_wr_addr] <= io.cfg_wr_data;
                    mask    <= mask_upd;
                    state   <= (io.cfg_commit && &mask_upd) ? HOLD : IDLE;
                    cfg_err <= (io.cfg_wr_en && !addr_ok) || (io.cfg_commit && !(&mask_upd));
                end
                HOLD: begin
                    state   <= SWAP;
                    cfg_err <= busy_err;
                end
                SWAP: begin
                    cfg_err  <= busy_err;
                    bank_sel <= ~bank_sel;
                    mask     <= '0;
                    for (int k = 0; k < FN; k++)
                        coeff_out[k*CW +: CW] <= bank[~bank_sel][k];
                    if (FLUSH_EN != 0) begin
                        state     <= FLUSH;
                        fir_clear <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        swap_done <= 1'b1;
                        swap_cnt  <= swap_cnt + 8'd1;
                    end
                end
                FLUSH: begin
                    cfg_err   <= busy_err;
                    state     <= IDLE;
                    swap_done <= 1'b1;
                    swap_cnt  <= swap_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_coeff_bank_ctrl.sv
// tb_fir_coeff_bank_ctrl: directed per-cycle expectations pushed to a scoreboard, checked by a negedge monitor
module tb_fir_coeff_bank_ctrl;
    localparam int CW = 10;
    localparam int FW = 13;
    localparam int FN = (FW + 1) / 2;
    localparam int AW = $clog2(FN);

    typedef struct {
        logic             rdy;
        logic             fc;
        logic             er;
        logic             dn;
        logic             bs;
        logic             iv;
        logic [7:0]       cnt;
        logic [FN*CW-1:0] cf;
        int               id;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic vld_g = 1'b0;
    logic             e_bs = 1'b0;
    logic [7:0]       e_cnt = '0;
    logic [FN*CW-1:0] e_coeff = '0;
    exp_t sb[$];
    exp_t e;
    int   cyc_id = 0;
    int   checks = 0;
    int   errors = 0;

    fir_coeff_bank_ctrl_if #(.CW(CW), .FN(FN), .AW(AW)) bus ();

    fir_coeff_bank_ctrl #(.CW(CW), .FW(FW), .FLUSH_EN(1)) dut (
        .clk (clk),
        .rstn(rstn),
        .io  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [FN*CW-1:0] cf_lin(input int base, input int step);
        logic [FN*CW-1:0] v;
        for (int k = 0; k < FN; k++) v[k*CW +: CW] = CW'(base + step * k);
        return v;
    endfunction

    // one clock: apply inputs just after the edge and queue what the outputs must show this cycle
    task automatic cyc(input logic wr, input int a, input int d, input logic cm, input logic cl,
                       input logic rn, input logic r, input logic fc, input logic er, input logic dn);
        exp_t x;
        @(posedge clk);
        #1;
        rstn             = rn;
        bus.cfg_wr_en    = wr;
        bus.cfg_wr_addr  = AW'(a);
        bus.cfg_wr_data  = CW'(d);
        bus.cfg_commit   = cm;
        bus.clear        = cl;
        bus.data_in_vld  = vld_g;
        x.rdy = r; x.fc = fc; x.er = er; x.dn = dn;
        x.bs = e_bs; x.iv = r & vld_g; x.cnt = e_cnt; x.cf = e_coeff; x.id = cyc_id;
        sb.push_back(x);
        cyc_id++;
    endtask

    task automatic nop(input logic r, input logic fc, input logic er, input logic dn);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, r, fc, er, dn);
    endtask

    task automatic wrt(input int a, input int d, input logic er);
        cyc(1'b1, a, d, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, er, 1'b0);
    endtask

    task automatic commit_idle();
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // monitor: pop one expectation per cycle and compare every observable output
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({bus.in_rdy, bus.cfg_busy, bus.fir_clear, bus.cfg_err, bus.swap_done, bus.bank_sel,
                 bus.fir_in_vld, bus.swap_cnt, bus.coeff_out} !==
                {e.rdy, ~e.rdy, e.fc, e.er, e.dn, e.bs, e.iv, e.cnt, e.cf}) begin
                errors++;
                $display("FAIL cyc%0d got rdy=%b busy=%b fclr=%b err=%b done=%b bs=%b ivld=%b cnt=%0d coeff=%h | want rdy=%b busy=%b fclr=%b err=%b done=%b bs=%b ivld=%b cnt=%0d coeff=%h",
                         e.id, bus.in_rdy, bus.cfg_busy, bus.fir_clear, bus.cfg_err, bus.swap_done,
                         bus.bank_sel, bus.fir_in_vld, bus.swap_cnt, bus.coeff_out,
                         e.rdy, ~e.rdy, e.fc, e.er, e.dn, e.bs, e.iv, e.cnt, e.cf);
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: stimulus did not finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        bus.clear = 1'b0; bus.cfg_wr_en = 1'b0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0;
        bus.cfg_commit = 1'b0; bus.data_in_vld = 1'b0;
        repeat (2) @(posedge clk);
        // reset values
        nop(1, 0, 0, 0);
        nop(1, 0, 0, 0);
        checks++;
        if (bus.coeff_out !== '0 || bus.bank_sel !== 1'b0 || bus.in_rdy !== 1'b1 || bus.swap_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset state coeff=%h bs=%b rdy=%b cnt=%0d", bus.coeff_out, bus.bank_sel, bus.in_rdy, bus.swap_cnt);
        end

        // full bank k+1, commit with a continuous sample stream
        vld_g = 1'b1;
        for (int k = 0; k < FN; k++) wrt(k, k + 1, 0);
        commit_idle();
        nop(0, 0, 0, 0);
        nop(0, 0, 0, 0);
        e_bs = 1'b1; e_coeff = cf_lin(1, 1);
        nop(0, 1, 0, 0);
        e_cnt = 8'd1;
        nop(1, 0, 0, 1);
        nop(1, 0, 0, 0);

        // incomplete mask: error, no stall; then last tap + commit in one cycle
        vld_g = 1'b0;
        for (int k = 0; k < FN - 1; k++) wrt(k, 10 * (k + 1), 0);
        commit_idle();
        nop(1, 0, 1, 0);
        vld_g = 1'b1;
        nop(1, 0, 0, 0);
        cyc(1'b1, FN - 1, 10 * FN, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0);
        nop(0, 0, 0, 0);
        nop(0, 0, 0, 0);
        e_bs = 1'b0; e_coeff = cf_lin(10, 10);
        nop(0, 1, 0, 0);
        e_cnt = 8'd2;
        nop(1, 0, 0, 1);

        // out-of-range address, write during HOLD and commit during SWAP all flagged
        wrt(FN, 123, 0);
        for (int k = 0; k < FN; k++) wrt(k, 100 + k, k == 0);
        commit_idle();
        cyc(1'b1, 0, 999, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 0, 0, 1, 0);
        e_bs = 1'b1; e_coeff = cf_lin(100, 1);
        nop(0, 1, 1, 0);
        e_cnt = 8'd3;
        nop(1, 0, 0, 1);

        // soft clear during HOLD aborts the swap and empties the mask
        for (int k = 0; k < FN; k++) wrt(k, 200 + k, 0);
        commit_idle();
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
        nop(1, 1, 0, 0);
        commit_idle();
        nop(1, 0, 1, 0);
        for (int k = 0; k < FN; k++) wrt(k, (k == 2) ? 300 : 200 + k, 0);
        wrt(2, 301, 0);
        commit_idle();
        nop(0, 0, 0, 0);
        nop(0, 0, 0, 0);
        e_bs = 1'b0; e_coeff = cf_lin(200, 1); e_coeff[2*CW +: CW] = 10'd301;
        nop(0, 1, 0, 0);
        e_cnt = 8'd4;
        nop(1, 0, 0, 1);

        // hard reset in SWAP: back to reset values, no completion pulse
        for (int k = 0; k < FN; k++) wrt(k, 50 + k, 0);
        commit_idle();
        nop(0, 0, 0, 0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        e_bs = 1'b0; e_cnt = 8'd0; e_coeff = '0;
        nop(1, 0, 0, 0);
        nop(1, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
